// File: rtl/usbf_ulpi_reg_sched.sv
`default_nettype none
// ============================================================================
// Module   : usbf_ulpi_reg_sched
// Purpose  : Round-robin arbiter and sequencer for ULPI PHY register accesses
//            from two requesters (0 = CSR bridge, 1 = internal link logic).
//            Aborts are retried after a backoff. Persistent failure is
//            returned as an error response.
// Options  : USBF_ULPI_REG_TIMEOUT_EN - enables the ISSUE-state timeout
// Revision : 1.0 - initial release
// ============================================================================
module usbf_ulpi_reg_sched #(
  parameter int RETRY_MAX      = 3,
  parameter int BACKOFF_CYCLES = 4,
  parameter int TIMEOUT_CYCLES = 255
) (
  input  logic        ulpi_clk60_i,
  input  logic        ulpi_rst_i,
  input  logic [1:0]  req_valid_i,
  input  logic [1:0]  req_we_i,
  input  logic [11:0] req_addr_i,
  input  logic [15:0] req_wdata_i,
  output logic [1:0]  req_ready_o,
  output logic [1:0]  resp_valid_o,
  output logic [7:0]  resp_rdata_o,
  output logic        resp_err_o,
  output logic        reg_req_o,
  output logic        reg_we_o,
  output logic [5:0]  reg_addr_o,
  output logic [7:0]  reg_wdata_o,
  input  logic        reg_ack_i,
  input  logic        reg_abort_i,
  input  logic [7:0]  reg_rdata_i,
  output logic        busy_o
);

  localparam int RW = (RETRY_MAX < 1) ? 1 : $clog2(RETRY_MAX + 1);
  localparam int BW = (BACKOFF_CYCLES <= 2) ? 1 : $clog2(BACKOFF_CYCLES);
  localparam logic [RW-1:0] RETRY_LIM = RW'(RETRY_MAX);
  // Backoff counter counts down to zero, so BACKOFF_CYCLES idle cycles need
  // a load value of BACKOFF_CYCLES-1.
  localparam logic [BW-1:0] BO_LOAD   = BW'(BACKOFF_CYCLES - 1);

  typedef enum logic [1:0] {
    S_IDLE    = 2'd0,
    S_ISSUE   = 2'd1,
    S_BACKOFF = 2'd2,
    S_DONE    = 2'd3
  } state_e;

  state_e          state_q;
  logic            last_grant_q;
  logic            grant_q;
  logic [RW-1:0]   retry_cnt_q;
  logic [BW-1:0]   backoff_cnt_q;
  logic            reg_req_q;
  logic            reg_we_q;
  logic [5:0]      reg_addr_q;
  logic [7:0]      reg_wdata_q;
  logic [1:0]      resp_valid_q;
  logic [7:0]      resp_rdata_q;
  logic            err_q;
  logic            busy_q;

  logic            grant_d;
  logic            accept;
  logic [1:0]      req_ready;

`ifdef USBF_ULPI_REG_TIMEOUT_EN
  localparam int TW = (TIMEOUT_CYCLES < 1) ? 1 : $clog2(TIMEOUT_CYCLES + 1);
  // Counter starts at 0 on ISSUE entry; the TIMEOUT_CYCLES-th ISSUE cycle
  // is the last one before giving up.
  localparam logic [TW-1:0] TO_LAST = TW'(TIMEOUT_CYCLES - 1);
  logic [TW-1:0]   to_cnt_q;
`else
  // Timeout hardware is absent in this build; the parameter stays in the
  // interface so both builds share one instantiation.
  if (TIMEOUT_CYCLES > 0) begin : g_timeout_unused
  end
`endif

  // Round-robin pick: on a tie the port that did not win last time is chosen.
  always_comb begin
    grant_d   = req_valid_i[1];
    if (&req_valid_i) begin
      grant_d = ~last_grant_q;
    end
    accept    = (state_q == S_IDLE) && (|req_valid_i);
    req_ready = 2'b00;
    if (accept) begin
      req_ready[grant_d] = 1'b1;
    end
  end

  assign req_ready_o  = req_ready;
  assign resp_valid_o = resp_valid_q;
  assign resp_rdata_o = resp_rdata_q;
  assign resp_err_o   = err_q;
  assign reg_req_o    = reg_req_q;
  assign reg_we_o     = reg_we_q;
  assign reg_addr_o   = reg_addr_q;
  assign reg_wdata_o  = reg_wdata_q;
  assign busy_o       = busy_q;

  // Access sequencer: accept, issue, retry after backoff, respond.
  always_ff @(posedge ulpi_clk60_i) begin
    if (ulpi_rst_i) begin
      state_q       <= S_IDLE;
      last_grant_q  <= 1'b1;
      grant_q       <= 1'b0;
      retry_cnt_q   <= '0;
      backoff_cnt_q <= '0;
      reg_req_q     <= 1'b0;
      reg_we_q      <= 1'b0;
      reg_addr_q    <= '0;
      reg_wdata_q   <= '0;
      resp_valid_q  <= '0;
      resp_rdata_q  <= '0;
      err_q         <= 1'b0;
      busy_q        <= 1'b0;
`ifdef USBF_ULPI_REG_TIMEOUT_EN
      to_cnt_q      <= '0;
`endif
    end else begin
      // Response is a single-cycle pulse raised only on entry to DONE.
      resp_valid_q <= '0;
      case (state_q)
        S_IDLE: begin
          if (accept) begin
            grant_q      <= grant_d;
            last_grant_q <= grant_d;
            reg_we_q     <= req_we_i[grant_d];
            reg_addr_q   <= grant_d ? req_addr_i[11:6]  : req_addr_i[5:0];
            reg_wdata_q  <= grant_d ? req_wdata_i[15:8] : req_wdata_i[7:0];
            retry_cnt_q  <= '0;
            err_q        <= 1'b0;
            reg_req_q    <= 1'b1;
            busy_q       <= 1'b1;
            state_q      <= S_ISSUE;
`ifdef USBF_ULPI_REG_TIMEOUT_EN
            to_cnt_q     <= '0;
`endif
          end
        end
        S_ISSUE: begin
          // Ack has priority over a coincident abort (and over timeout).
          if (reg_ack_i) begin
            resp_rdata_q          <= reg_rdata_i;
            err_q                 <= 1'b0;
            reg_req_q             <= 1'b0;
            resp_valid_q[grant_q] <= 1'b1;
            state_q               <= S_DONE;
          end else if (reg_abort_i) begin
            reg_req_q <= 1'b0;
            if (retry_cnt_q < RETRY_LIM) begin
              retry_cnt_q   <= retry_cnt_q + 1'b1;
              backoff_cnt_q <= BO_LOAD;
              state_q       <= S_BACKOFF;
            end else begin
              err_q                 <= 1'b1;
              resp_valid_q[grant_q] <= 1'b1;
              state_q               <= S_DONE;
            end
          end
`ifdef USBF_ULPI_REG_TIMEOUT_EN
          else if (to_cnt_q == TO_LAST) begin
            reg_req_q             <= 1'b0;
            err_q                 <= 1'b1;
            resp_valid_q[grant_q] <= 1'b1;
            state_q               <= S_DONE;
          end else begin
            to_cnt_q <= to_cnt_q + 1'b1;
          end
`endif
        end
        S_BACKOFF: begin
          if (backoff_cnt_q == '0) begin
            reg_req_q <= 1'b1;
            state_q   <= S_ISSUE;
`ifdef USBF_ULPI_REG_TIMEOUT_EN
            to_cnt_q  <= '0;
`endif
          end else begin
            backoff_cnt_q <= backoff_cnt_q - 1'b1;
          end
        end
        S_DONE: begin
          busy_q  <= 1'b0;
          state_q <= S_IDLE;
        end
        default: begin
          busy_q  <= 1'b0;
          state_q <= S_IDLE;
        end
      endcase
    end
  end

endmodule
`default_nettype wire
